div_steps: RTL and testbench



---
 rtl/div_steps_pkg.sv | 19 +
 rtl/div_steps_slice.sv | 27 ++
 rtl/div_steps.sv | 102 ++++++++++
 tb/tb_div_steps.sv | 171 +++++++++++++++++
 4 files changed

// File: rtl/div_steps_pkg.sv
// Shared widths, step count and FSM state type for the div_steps restoring divider.
package div_steps_pkg;

    localparam int OPERAND_W  = 32;
    localparam int RESULT_W   = 64;
    localparam int STEP_COUNT = 64;
    localparam int CNT_W      = $clog2(STEP_COUNT);
    localparam int REM_W      = OPERAND_W + 1;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } div_state_e;

    function automatic logic is_last_step(input logic [CNT_W-1:0] cnt);
        return cnt == CNT_W'(STEP_COUNT - 1);
    endfunction

endpackage

// File: rtl/div_steps_slice.sv
// One restoring-division step: shift a numerator bit into the remainder, then
// subtract the divisor when it fits.
module div_step_slice
    import div_steps_pkg::*;
(
    input  logic [REM_W-1:0]     rem_i,
    input  logic                 num_bit_i,
    input  logic [OPERAND_W-1:0] den_i,
    output logic [REM_W-1:0]     rem_o,
    output logic                 q_bit_o
);

    logic [REM_W-1:0] shifted;
    logic [REM_W-1:0] den_ext;
    logic             fits;

    // The restored remainder is always below D, so its top bit is zero and
    // dropping it in the shift loses nothing.
    always_comb begin
        shifted = {rem_i[REM_W-2:0], num_bit_i};
        den_ext = {1'b0, den_i};
        fits    = (shifted >= den_ext);
        q_bit_o = fits;
        rem_o   = fits ? (shifted - den_ext) : shifted;
    end

endmodule

// File: rtl/div_steps.sv
// Sequential 32.32 fixed-point unsigned divider: floor(dividend * 2^32 / divisor),
// one quotient bit per enabled clock.
module div_steps
    import div_steps_pkg::*;
(
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 clk_en_i,
    input  logic                 divide_i,
    input  logic [OPERAND_W-1:0] dividend_i,
    input  logic [OPERAND_W-1:0] divisor_i,
    output logic [RESULT_W-1:0]  quotient_o,
    output logic                 done_o
);

    div_state_e           state_q,    state_d;
    logic [CNT_W-1:0]     cnt_q,      cnt_d;
    logic [RESULT_W-1:0]  num_q,      num_d;
    logic [OPERAND_W-1:0] den_q,      den_d;
    logic [REM_W-1:0]     rem_q,      rem_d;
    logic [RESULT_W-1:0]  acc_q,      acc_d;
    logic [RESULT_W-1:0]  quotient_q, quotient_d;
    logic                 done_q,     done_d;

    logic [REM_W-1:0]     slice_rem;
    logic                 slice_q_bit;

    // The numerator is shifted left each step, so its MSB is always the next bit.
    div_step_slice u_slice (
        .rem_i     (rem_q),
        .num_bit_i (num_q[RESULT_W-1]),
        .den_i     (den_q),
        .rem_o     (slice_rem),
        .q_bit_o   (slice_q_bit)
    );

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        num_d      = num_q;
        den_d      = den_q;
        rem_d      = rem_q;
        acc_d      = acc_q;
        quotient_d = quotient_q;
        done_d     = done_q;

        if (clk_en_i) begin
            case (state_q)
                IDLE: begin
                    if (divide_i) begin
                        num_d   = {dividend_i, {OPERAND_W{1'b0}}};
                        den_d   = divisor_i;
                        rem_d   = '0;
                        cnt_d   = '0;
                        acc_d   = '0;
                        done_d  = 1'b0;
                        state_d = BUSY;
                    end
                end
                BUSY: begin
                    rem_d = slice_rem;
                    num_d = {num_q[RESULT_W-2:0], 1'b0};
                    acc_d = {acc_q[RESULT_W-2:0], slice_q_bit};
                    cnt_d = cnt_q + CNT_W'(1);
                    // The output register only moves once the full quotient exists.
                    if (is_last_step(cnt_q)) begin
                        quotient_d = acc_d;
                        done_d     = 1'b1;
                        state_d    = IDLE;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            num_q      <= '0;
            den_q      <= '0;
            rem_q      <= '0;
            acc_q      <= '0;
            quotient_q <= '0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            num_q      <= num_d;
            den_q      <= den_d;
            rem_q      <= rem_d;
            acc_q      <= acc_d;
            quotient_q <= quotient_d;
            done_q     <= done_d;
        end
    end

    assign quotient_o = quotient_q;
    assign done_o     = done_q;

endmodule

// File: tb/tb_div_steps.sv
// Directed scoreboard bench for div_steps: expected quotients are queued at start
// and compared when done_o rises.
module tb_div_steps;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        clk_en_i;
    logic        divide_i;
    logic [31:0] dividend_i;
    logic [31:0] divisor_i;
    logic [63:0] quotient_o;
    logic        done_o;

    logic [63:0] exp_q[$];
    int          n_vec     = 0;
    int          n_miscmp  = 0;

    div_steps dut (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .clk_en_i   (clk_en_i),
        .divide_i   (divide_i),
        .dividend_i (dividend_i),
        .divisor_i  (divisor_i),
        .quotient_o (quotient_o),
        .done_o     (done_o)
    );

    always #5 clk_i = ~clk_i;

    function automatic logic [63:0] golden(input logic [31:0] a, input logic [31:0] b);
        logic [63:0] n;
        logic [63:0] d;
        n = {a, 32'h0};
        d = {32'h0, b};
        if (b == 32'h0) return 64'hFFFF_FFFF_FFFF_FFFF;
        return n / d;
    endfunction

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        n_vec++;
        assert (obs === expv) else begin
            n_miscmp++;
            $error("[TB] FAIL %s: observed %h, expected %h", tag, obs, expv);
        end
    endtask

    // Drive one start edge; the operands are scrambled right after it.
    task automatic applyStimulus(input logic [31:0] a, input logic [31:0] b,
                                 input logic [63:0] expv);
        logic [63:0] prev_q;
        prev_q     = quotient_o;
        dividend_i = a;
        divisor_i  = b;
        clk_en_i   = 1'b1;
        divide_i   = 1'b1;
        exp_q.push_back(expv);
        tick();
        divide_i   = 1'b0;
        dividend_i = $urandom;
        divisor_i  = $urandom;
        checkOutput("done_drops_on_start", {63'h0, done_o}, 64'h0);
        checkOutput("quotient_held_on_start", quotient_o, prev_q);
    endtask

    task automatic waitDone(input string tag, input bit random_en);
        int          en_edges;
        int          budget;
        logic        en_now;
        logic        held_ok;
        logic [63:0] prev_q;
        logic [63:0] expv;
        en_edges = 0;
        budget   = 1000;
        held_ok  = 1'b1;
        prev_q   = quotient_o;
        while (budget > 0) begin
            en_now = random_en ? ($urandom_range(0, 2) != 0) : 1'b1;
            clk_en_i = en_now;
            if (random_en) begin
                divide_i   = ($urandom_range(0, 5) == 0);
                dividend_i = $urandom;
                divisor_i  = $urandom;
            end
            tick();
            if (en_now) en_edges++;
            if (done_o === 1'b1) break;
            if (quotient_o !== prev_q) held_ok = 1'b0;
            budget--;
        end
        clk_en_i = 1'b1;
        divide_i = 1'b0;
        expv = exp_q.pop_front();
        checkOutput({tag, "_latency"}, 64'(en_edges), 64'd64);
        checkOutput({tag, "_done"}, {63'h0, done_o}, 64'h1);
        checkOutput({tag, "_held_while_busy"}, {63'h0, held_ok}, 64'h1);
        checkOutput({tag, "_quotient"}, quotient_o, expv);
    endtask

    initial begin
        rst_i      = 1'b1;
        clk_en_i   = 1'b0;
        divide_i   = 1'b0;
        dividend_i = '0;
        divisor_i  = '0;
        #3;
        checkOutput("reset_done", {63'h0, done_o}, 64'h0);
        checkOutput("reset_quotient", quotient_o, 64'h0);
        tick();
        tick();
        rst_i = 1'b0;
        tick();

        applyStimulus(32'd2, 32'd1, 64'h00000002_00000000);
        waitDone("div_2_1", 1'b0);

        applyStimulus(32'd200, 32'd3, 64'h00000042_AAAAAAAA);
        waitDone("div_200_3", 1'b0);

        applyStimulus(32'hDFFF1234, 32'd3, 64'h4AAA5B66_AAAAAAAA);
        waitDone("div_big_3", 1'b0);

        applyStimulus(32'd3, 32'hDFFF1234, 64'h00000000_00000003);
        waitDone("div_3_big", 1'b0);

        applyStimulus(32'h60002000, 32'h56000000, golden(32'h60002000, 32'h56000000));
        waitDone("div_close", 1'b0);
        checkOutput("div_close_int", {32'h0, quotient_o[63:32]}, 64'h1);

        applyStimulus(32'd5, 32'd0, 64'hFFFF_FFFF_FFFF_FFFF);
        waitDone("div_by_zero", 1'b0);

        // Start requests under a disabled clock must be ignored.
        clk_en_i   = 1'b0;
        divide_i   = 1'b1;
        dividend_i = 32'd9;
        divisor_i  = 32'd4;
        repeat (3) tick();
        checkOutput("gated_start_done", {63'h0, done_o}, 64'h1);
        checkOutput("gated_start_quotient", quotient_o, 64'hFFFF_FFFF_FFFF_FFFF);
        divide_i = 1'b0;
        clk_en_i = 1'b1;

        applyStimulus(32'd200, 32'd3, golden(32'd200, 32'd3));
        waitDone("div_200_3_gated", 1'b1);

        applyStimulus(32'd1000, 32'd7, golden(32'd1000, 32'd7));
        repeat (20) tick();
        #2;
        rst_i = 1'b1;
        #1;
        void'(exp_q.pop_back());
        checkOutput("abort_done", {63'h0, done_o}, 64'h0);
        checkOutput("abort_quotient", quotient_o, 64'h0);
        tick();
        rst_i = 1'b0;
        tick();

        applyStimulus(32'd7, 32'd2, 64'h00000003_80000000);
        waitDone("div_7_2", 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miscmp);
        $finish;
    end

endmodule
